// File: rtl/nand_flash_target_pkg.sv
// Shared definitions for the NAND flash target: command opcodes, FSM states and read-out modes.
package nand_flash_target_pkg;

    localparam logic [7:0] CMD_READ1  = 8'h00;
    localparam logic [7:0] CMD_READ2  = 8'h30;
    localparam logic [7:0] CMD_PROG1  = 8'h80;
    localparam logic [7:0] CMD_PROG2  = 8'h10;
    localparam logic [7:0] CMD_STATUS = 8'h70;
    localparam logic [7:0] CMD_ID     = 8'h90;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR     = 2'd1,
        ST_WAIT_CFM = 2'd2,
        ST_DIN      = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_PG = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        OM_DATA   = 2'd0,
        OM_STATUS = 2'd1,
        OM_ID     = 2'd2
    } out_mode_t;

endpackage

// File: rtl/nand_flash_target_strobe_sync.sv
// Edge detection on the active-low write/read strobes, qualified by chip enable.
module nand_strobe_sync (
    input  logic clk0,
    input  logic reset,
    input  logic ce,
    input  logic we,
    input  logic re,
    output logic we_rise_c,
    output logic re_fall_c
);

    logic we_q;
    logic re_q;

    // Strobes idle high, so the history flops reset high to avoid a false edge.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            we_q <= 1'b1;
            re_q <= 1'b1;
        end else begin
            we_q <= we;
            re_q <= re;
        end
    end

    assign we_rise_c = !ce && !we_q && we;
    assign re_fall_c = !ce && re_q && !re;

endmodule

// File: rtl/nand_flash_target.sv
// Pin-level NAND flash target: command/address latching, page read, program, status, ID and ready/busy.
module nand_flash_target
    import nand_flash_target_pkg::*;
#(
    parameter int unsigned PAGE_BYTES   = 16,
    parameter int unsigned PAGES        = 4,
    parameter int unsigned TR_CYCLES    = 8,
    parameter int unsigned TPROG_CYCLES = 32,
    parameter int unsigned TRST_CYCLES  = 4,
    parameter logic [7:0]  ID_BYTE0     = 8'hEC,
    parameter logic [7:0]  ID_BYTE1     = 8'h73
) (
    input  logic       clk0,
    input  logic       reset,
    input  logic       flash_ce,
    input  logic       flash_cle,
    input  logic       flash_ale,
    input  logic       flash_we,
    input  logic       flash_re,
    input  logic       flash_wp,
    input  logic [7:0] flash_din,
    output logic [7:0] flash_dout,
    output logic       flash_oe,
    output logic       flash_rb
);

    localparam int unsigned COL_W  = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int unsigned PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned CNT_W  = 16;

    state_t          state;
    op_t             op;
    out_mode_t       out_mode;
    logic [COL_W-1:0] col;
    logic [7:0]      page;
    logic            addr_cnt;
    logic [CNT_W-1:0] busy_cnt;
    logic            prog_pend;
    logic            fail;
    logic            id_idx;
    logic [7:0]      mem  [PAGES][PAGE_BYTES];
    logic [7:0]      pbuf [PAGE_BYTES];

    logic            we_rise_c;
    logic            re_fall_c;
    logic            busy_c;
    logic            page_ok_c;
    logic            is_cmd_c;
    logic            is_addr_c;
    logic            is_data_c;
    logic [COL_W-1:0] col_inc_c;
    logic [7:0]      rd_byte_c;
    logic [7:0]      status_c;

    nand_strobe_sync u_strobe (
        .clk0      (clk0),
        .reset     (reset),
        .ce        (flash_ce),
        .we        (flash_we),
        .re        (flash_re),
        .we_rise_c (we_rise_c),
        .re_fall_c (re_fall_c)
    );

    // Decode of the current byte and read-side data selection.
    always_comb begin
        busy_c    = (busy_cnt != '0);
        page_ok_c = (32'(page) < PAGES);
        is_cmd_c  = flash_cle && !flash_ale;
        is_addr_c = flash_ale && !flash_cle;
        is_data_c = !flash_ale && !flash_cle;
        col_inc_c = (32'(col) == PAGE_BYTES - 1) ? '0 : col + COL_W'(1);
        rd_byte_c = 8'hFF;
        if (page_ok_c) begin
            rd_byte_c = mem[page[PAGE_W-1:0]][col];
        end
        // Bit 7 high while the part is not write-protected.
        status_c  = {flash_wp, !busy_c, 5'b0, fail};
    end

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op         <= OP_RD;
            out_mode   <= OM_DATA;
            col        <= '0;
            page       <= '0;
            addr_cnt   <= 1'b0;
            busy_cnt   <= '0;
            prog_pend  <= 1'b0;
            fail       <= 1'b0;
            id_idx     <= 1'b0;
            flash_dout <= 8'h00;
            flash_oe   <= 1'b0;
            flash_rb   <= 1'b1;
            for (int p = 0; p < int'(PAGES); p++) begin
                for (int b = 0; b < int'(PAGE_BYTES); b++) begin
                    mem[p][b] <= 8'hFF;
                end
            end
            for (int b = 0; b < int'(PAGE_BYTES); b++) begin
                pbuf[b] <= 8'hFF;
            end
        end else begin
            flash_oe <= !flash_ce && !flash_re;
            flash_rb <= !busy_c;

            // Busy countdown; a pending program commits on the final step.
            if (busy_c) begin
                busy_cnt <= busy_cnt - CNT_W'(1);
                if (busy_cnt == CNT_W'(1) && prog_pend) begin
                    for (int b = 0; b < int'(PAGE_BYTES); b++) begin
                        mem[page[PAGE_W-1:0]][b] <= mem[page[PAGE_W-1:0]][b] & pbuf[b];
                    end
                    prog_pend <= 1'b0;
                end
            end

            if (we_rise_c) begin
                if (is_cmd_c) begin
                    if (flash_din == CMD_STATUS) begin
                        out_mode <= OM_STATUS;
                    end else if (flash_din == CMD_RESET) begin
                        state     <= ST_IDLE;
                        prog_pend <= 1'b0;
                        col       <= '0;
                        busy_cnt  <= CNT_W'(TRST_CYCLES);
                    end else if (!busy_c) begin
                        case (state)
                            ST_IDLE: begin
                                if (flash_din == CMD_READ1) begin
                                    state    <= ST_ADDR;
                                    op       <= OP_RD;
                                    addr_cnt <= 1'b0;
                                end else if (flash_din == CMD_PROG1) begin
                                    state    <= ST_ADDR;
                                    op       <= OP_PG;
                                    addr_cnt <= 1'b0;
                                    for (int b = 0; b < int'(PAGE_BYTES); b++) begin
                                        pbuf[b] <= 8'hFF;
                                    end
                                end else if (flash_din == CMD_ID) begin
                                    out_mode <= OM_ID;
                                    id_idx   <= 1'b0;
                                end
                            end
                            ST_ADDR: begin
                                state <= ST_IDLE;
                            end
                            ST_WAIT_CFM: begin
                                if (flash_din == CMD_READ2) begin
                                    busy_cnt <= CNT_W'(TR_CYCLES);
                                    out_mode <= OM_DATA;
                                end
                                state <= ST_IDLE;
                            end
                            ST_DIN: begin
                                if (flash_din == CMD_PROG2) begin
                                    if (!flash_wp || !page_ok_c) begin
                                        fail <= 1'b1;
                                    end else begin
                                        fail      <= 1'b0;
                                        prog_pend <= 1'b1;
                                    end
                                    busy_cnt <= CNT_W'(TPROG_CYCLES);
                                    state    <= ST_IDLE;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end else if (!busy_c && is_addr_c && state == ST_ADDR) begin
                    if (!addr_cnt) begin
                        col      <= flash_din[COL_W-1:0];
                        addr_cnt <= 1'b1;
                    end else begin
                        page  <= flash_din;
                        state <= (op == OP_PG) ? ST_DIN : ST_WAIT_CFM;
                    end
                end else if (!busy_c && is_data_c && state == ST_DIN) begin
                    pbuf[col] <= flash_din;
                    col       <= col_inc_c;
                end
            end else if (re_fall_c && (!busy_c || out_mode == OM_STATUS)) begin
                case (out_mode)
                    OM_DATA: begin
                        flash_dout <= rd_byte_c;
                        col        <= col_inc_c;
                    end
                    OM_STATUS: flash_dout <= status_c;
                    OM_ID: begin
                        flash_dout <= id_idx ? ID_BYTE1 : ID_BYTE0;
                        id_idx     <= 1'b1;
                    end
                    default: flash_dout <= 8'hFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nand_flash_target.sv
// Randomized self-checking bench for nand_flash_target against a page-array reference model.
module tb_nand_flash_target;

    localparam int PB = 16;
    localparam int NP = 4;

    logic       clk0 = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b0;
    logic       cle = 1'b0;
    logic       ale = 1'b0;
    logic       we = 1'b1;
    logic       re = 1'b1;
    logic       wp = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       oe;
    logic       rb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [NP][PB];
    logic       ref_fail;

    nand_flash_target dut (
        .clk0       (clk0),
        .reset      (reset),
        .flash_ce   (ce),
        .flash_cle  (cle),
        .flash_ale  (ale),
        .flash_we   (we),
        .flash_re   (re),
        .flash_wp   (wp),
        .flash_din  (din),
        .flash_dout (dout),
        .flash_oe   (oe),
        .flash_rb   (rb)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish (time %0t, required finish)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic wr(input logic c, input logic a, input logic [7:0] d);
        cle = c; ale = a; din = d; we = 1'b0;
        tick();
        we = 1'b1;
        tick();
        cle = 1'b0; ale = 1'b0;
    endtask

    task automatic rd(output logic [7:0] d, output logic o);
        re = 1'b0;
        tick();
        d = dout; o = oe;
        re = 1'b1;
        tick();
    endtask

    // Waits for rb to drop, then counts the cycles it stays low (bounded).
    task automatic wait_busy(output int n);
        n = 0;
        for (int i = 0; i < 8 && rb; i++) tick();
        while (!rb && n < 2000) begin
            n++;
            tick();
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < PB; b++) ref_mem[p][b] = 8'hFF;
        ref_fail = 1'b0;
    endfunction

    task automatic read_status(input string tag);
        logic [7:0] d;
        logic       o;
        wr(1, 0, 8'h70);
        rd(d, o);
        check(tag, d, {wp, rb, 5'b0, ref_fail});
    endtask

    task automatic read_page(input string tag, input int pg, input int c0, input int nbytes);
        logic [7:0] d, e;
        logic       o;
        int         n;
        wr(1, 0, 8'h00);
        wr(0, 1, 8'(c0));
        wr(0, 1, 8'(pg));
        wr(1, 0, 8'h30);
        wait_busy(n);
        check({tag, "_tr"}, n, 8);
        for (int k = 0; k < nbytes; k++) begin
            rd(d, o);
            e = (pg < NP) ? ref_mem[pg][(c0 + k) % PB] : 8'hFF;
            check($sformatf("%s_b%0d", tag, k), d, e);
        end
    endtask

    // Issues a program; model applies it only if wp is high and the page exists.
    task automatic do_prog(input string tag, input int pg, input int c0,
                           input logic [7:0] q[$], input bit wait_done);
        logic [7:0] buf_m [PB];
        int         n;
        for (int b = 0; b < PB; b++) buf_m[b] = 8'hFF;
        wr(1, 0, 8'h80);
        wr(0, 1, 8'(c0));
        wr(0, 1, 8'(pg));
        foreach (q[k]) begin
            buf_m[(c0 + k) % PB] = q[k];
            wr(0, 0, q[k]);
        end
        wr(1, 0, 8'h10);
        if (wp && pg < NP) begin
            for (int b = 0; b < PB; b++) ref_mem[pg][b] &= buf_m[b];
            ref_fail = 1'b0;
        end else begin
            ref_fail = 1'b1;
        end
        if (wait_done) begin
            wait_busy(n);
            check({tag, "_tprog"}, n, 32);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] d;
        logic       o;
        int         n, pg, c0, len, k;

        model_reset();
        tick();
        tick();
        check("rst_rb", rb, 1);
        check("rst_oe", oe, 0);
        check("rst_dout", dout, 8'h00);
        reset = 1'b1;
        tick();

        read_page("t1_erased", 1, 0, 16);

        q = '{8'hA5, 8'h3C};
        do_prog("t2", 2, 0, q, 1);
        read_page("t2_rd", 2, 0, 16);
        read_status("t2_status");
        check("t2_status_c0", dout, 8'hC0);

        wp = 1'b0;
        q = '{8'h00};
        do_prog("t3", 1, 0, q, 1);
        read_status("t3_status");
        check("t3_status_41", dout, 8'h41);
        wp = 1'b1;
        read_page("t3_rd", 1, 0, 16);

        q = '{8'h12, 8'h34};
        do_prog("t4", 7, 0, q, 0);
        wr(1, 0, 8'h70);
        rd(d, o);
        check("t4_busy_status", d, 8'h81);
        wr(1, 0, 8'h00);
        k = 0;
        while (!rb && k < 200) begin
            tick();
            k++;
        end
        check("t4_rb_return", rb, 1);
        read_status("t4_status_done");
        read_page("t4_rd_after", 2, 0, 4);

        for (int r = 0; r < 8; r++) begin
            pg  = $urandom_range(0, 4);
            pg  = (pg == 4) ? 7 : pg;
            c0  = $urandom_range(0, PB - 1);
            len = $urandom_range(1, 20);
            wp  = ($urandom_range(0, 3) != 0);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            do_prog($sformatf("r%0d", r), pg, c0, q, 1);
            read_status($sformatf("r%0d_status", r));
            wp = 1'b1;
            read_page($sformatf("r%0d_rd", r), pg, $urandom_range(0, PB - 1), 16);
        end

        read_page("t5_wrap", 0, 15, 2);
        wr(1, 0, 8'h90);
        rd(d, o);
        check("t5_id0", d, 8'hEC);
        check("t5_oe", o, 1);
        rd(d, o);
        check("t5_id1", d, 8'h73);
        rd(d, o);
        check("t5_id2", d, 8'h73);
        check("t5_oe_idle", oe, 0);

        q = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_prog("t6", 3, 0, q, 0);
        for (int i = 0; i < 10; i++) tick();
        check("t6_busy_before_rst", rb, 0);
        reset = 1'b0;
        #2;
        check("t6_rst_rb", rb, 1);
        check("t6_rst_dout", dout, 8'h00);
        model_reset();
        tick();
        reset = 1'b1;
        tick();
        read_page("t6_rd", 3, 0, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
